// File: rtl/rs_int_pkg.sv
// Shared types and sizing for the integer reservation station.
package rs_int_pkg;

    localparam int unsigned RS_NUM_ENTRIES = 8;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned PRF_IDX_W      = 7;
    localparam int unsigned ROB_IDX_W      = 6;

    typedef enum logic [1:0] {
        OP_REG  = 2'd0,
        OP_IMM  = 2'd1,
        OP_ZERO = 2'd2,
        OP_PC   = 2'd3
    } t_optype;

    typedef struct packed {
        logic [7:0]  opcode;
        t_optype     src1_optype;
        t_optype     src2_optype;
        logic [15:0] imm;
    } t_uinstr;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] robid;
    } t_nuke_pkt;

    typedef struct packed {
        logic [PRF_IDX_W-1:0] pdst;
        logic [XLEN-1:0]      data;
    } t_prf_wr_pkt;

    typedef struct packed {
        t_uinstr              uinstr;
        logic [ROB_IDX_W-1:0] robid;
        logic [PRF_IDX_W-1:0] pdst;
        logic [XLEN-1:0]      src1_val;
        logic [XLEN-1:0]      src2_val;
    } t_iss_pkt;

    typedef struct packed {
        t_uinstr              uinstr;
        logic [ROB_IDX_W-1:0] robid;
        logic [PRF_IDX_W-1:0] pdst;
        logic [PRF_IDX_W-1:0] psrc1;
        logic [PRF_IDX_W-1:0] psrc2;
        logic                 src1_rdy;
        logic                 src2_rdy;
        logic [XLEN-1:0]      src1_val;
        logic [XLEN-1:0]      src2_val;
    } t_rs_disp_pkt;

    // A not-yet-ready source is satisfied by this cycle's PRF writeback.
    function automatic logic wb_hit(input logic                 rdy,
                                    input logic [PRF_IDX_W-1:0] psrc,
                                    input logic                 wr_en,
                                    input t_prf_wr_pkt          wr);
        return wr_en && !rdy && (psrc == wr.pdst);
    endfunction

endpackage

// File: rtl/rs_int_age.sv
// Age matrix: tracks relative allocation order and grants the oldest requester.
module rs_age_matrix #(
    parameter int unsigned NUM_ENTRIES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] alloc,
    input  logic [NUM_ENTRIES-1:0] free,
    input  logic [NUM_ENTRIES-1:0] req,
    output logic [NUM_ENTRIES-1:0] grant
);

    logic [NUM_ENTRIES-1:0] older [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] live;
    logic [NUM_ENTRIES-1:0] keep;
    logic [NUM_ENTRIES-1:0] blocked;

    assign keep = live & ~free;

    always_ff @(posedge clk) begin
        if (reset) begin
            live <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                older[i] <= '0;
            end
        end else begin
            live <= keep | alloc;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (alloc[i]) begin
                    older[i] <= '0;
                end else if (keep[i]) begin
                    older[i] <= older[i] | alloc;
                end
            end
        end
    end

    // An entry is blocked when any older entry is also requesting.
    always_comb begin
        blocked = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            for (int unsigned j = 0; j < NUM_ENTRIES; j++) begin
                if (req[j] && older[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
        end
    end

    assign grant = req & ~blocked;

endmodule

// File: rtl/rs_int.sv
// Integer reservation station: data-capture wakeup, oldest-ready single issue.
module rs_int
    import rs_int_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = RS_NUM_ENTRIES
) (
    input  logic         clk,
    input  logic         reset,
    input  t_nuke_pkt    nuke_rb1,
    input  logic         disp_valid_rs0,
    input  t_rs_disp_pkt disp_pkt_rs0,
    output logic         rs_full_rs0,
    input  logic         iprf_wr_en_ex1,
    input  t_prf_wr_pkt  iprf_wr_pkt_ex1,
    output logic         iss_ex0,
    output t_iss_pkt     iss_pkt_ex0
);

    localparam int unsigned RS_IDX_W = $clog2(NUM_ENTRIES);

    t_rs_disp_pkt           ent [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid;
    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES-1:0] low_free;
    logic [NUM_ENTRIES-1:0] alloc_oh;
    logic [NUM_ENTRIES-1:0] rdy_vec;
    logic [NUM_ENTRIES-1:0] req;
    logic [NUM_ENTRIES-1:0] grant;
    logic [NUM_ENTRIES-1:0] release_vec;
    logic [RS_IDX_W-1:0]    sel_idx;
    logic                   nuke;
    logic                   nuke_robid_unused;
    t_rs_disp_pkt           disp_wr;

    assign nuke              = nuke_rb1.valid;
    assign nuke_robid_unused = ^nuke_rb1.robid;
    assign rs_full_rs0       = &valid;

    // Lowest-index free entry via x & -x.
    assign free_vec = ~valid;
    assign low_free = free_vec & (~free_vec + NUM_ENTRIES'(1));
    assign alloc_oh = (disp_valid_rs0 && !nuke) ? low_free : '0;

    // Dispatch payload with immediate-source readiness and writeback bypass.
    always_comb begin
        disp_wr = disp_pkt_rs0;
        disp_wr.src1_rdy = disp_pkt_rs0.src1_rdy || (disp_pkt_rs0.uinstr.src1_optype != OP_REG);
        disp_wr.src2_rdy = disp_pkt_rs0.src2_rdy || (disp_pkt_rs0.uinstr.src2_optype != OP_REG);
        if (wb_hit(disp_wr.src1_rdy, disp_pkt_rs0.psrc1, iprf_wr_en_ex1, iprf_wr_pkt_ex1)) begin
            disp_wr.src1_rdy = 1'b1;
            disp_wr.src1_val = iprf_wr_pkt_ex1.data;
        end
        if (wb_hit(disp_wr.src2_rdy, disp_pkt_rs0.psrc2, iprf_wr_en_ex1, iprf_wr_pkt_ex1)) begin
            disp_wr.src2_rdy = 1'b1;
            disp_wr.src2_val = iprf_wr_pkt_ex1.data;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            rdy_vec[i] = ent[i].src1_rdy && ent[i].src2_rdy;
        end
    end

    assign req         = valid & rdy_vec & {NUM_ENTRIES{!nuke}};
    assign release_vec = nuke ? '1 : grant;

    rs_age_matrix #(.NUM_ENTRIES(NUM_ENTRIES)) u_age (
        .clk   (clk),
        .reset (reset),
        .alloc (alloc_oh),
        .free  (release_vec),
        .req   (req),
        .grant (grant)
    );

    always_comb begin
        sel_idx = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i]) begin
                sel_idx = RS_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
        end else begin
            valid <= nuke ? '0 : ((valid & ~grant) | alloc_oh);
        end
    end

    // Entry payload: allocation write or in-place operand capture.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (alloc_oh[i]) begin
                ent[i] <= disp_wr;
            end else if (valid[i]) begin
                if (wb_hit(ent[i].src1_rdy, ent[i].psrc1, iprf_wr_en_ex1, iprf_wr_pkt_ex1)) begin
                    ent[i].src1_rdy <= 1'b1;
                    ent[i].src1_val <= iprf_wr_pkt_ex1.data;
                end
                if (wb_hit(ent[i].src2_rdy, ent[i].psrc2, iprf_wr_en_ex1, iprf_wr_pkt_ex1)) begin
                    ent[i].src2_rdy <= 1'b1;
                    ent[i].src2_val <= iprf_wr_pkt_ex1.data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            iss_ex0     <= 1'b0;
            iss_pkt_ex0 <= '0;
        end else begin
            iss_ex0 <= |grant;
            if (|grant) begin
                iss_pkt_ex0.uinstr   <= ent[sel_idx].uinstr;
                iss_pkt_ex0.robid    <= ent[sel_idx].robid;
                iss_pkt_ex0.pdst     <= ent[sel_idx].pdst;
                iss_pkt_ex0.src1_val <= ent[sel_idx].src1_val;
                iss_pkt_ex0.src2_val <= ent[sel_idx].src2_val;
            end
        end
    end

    a_one_grant: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
    a_grant_rdy: assert property (@(posedge clk) disable iff (reset) ((grant & ~rdy_vec) == '0));
    a_no_full_disp: assert property (@(posedge clk) disable iff (reset) !(disp_valid_rs0 && rs_full_rs0));

endmodule

// File: tb/tb_rs_int.sv
// Directed self-checking bench for rs_int.
module tb_rs_int;
    import rs_int_pkg::*;

    logic         clk;
    logic         reset;
    t_nuke_pkt    nuke_rb1;
    logic         disp_valid_rs0;
    t_rs_disp_pkt disp_pkt_rs0;
    logic         rs_full_rs0;
    logic         iprf_wr_en_ex1;
    t_prf_wr_pkt  iprf_wr_pkt_ex1;
    logic         iss_ex0;
    t_iss_pkt     iss_pkt_ex0;

    int checks = 0;
    int errors = 0;

    rs_int #(.NUM_ENTRIES(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .nuke_rb1        (nuke_rb1),
        .disp_valid_rs0  (disp_valid_rs0),
        .disp_pkt_rs0    (disp_pkt_rs0),
        .rs_full_rs0     (rs_full_rs0),
        .iprf_wr_en_ex1  (iprf_wr_en_ex1),
        .iprf_wr_pkt_ex1 (iprf_wr_pkt_ex1),
        .iss_ex0         (iss_ex0),
        .iss_pkt_ex0     (iss_pkt_ex0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        disp_valid_rs0  = 1'b0;
        disp_pkt_rs0    = '0;
        iprf_wr_en_ex1  = 1'b0;
        iprf_wr_pkt_ex1 = '0;
        nuke_rb1        = '0;
    endtask

    task automatic set_disp(input logic [5:0] robid,
                            input logic [6:0] psrc1, input logic rdy1, input logic [31:0] val1,
                            input logic [6:0] psrc2, input logic rdy2, input logic [31:0] val2);
        disp_valid_rs0                  = 1'b1;
        disp_pkt_rs0                    = '0;
        disp_pkt_rs0.uinstr.opcode      = 8'h01;
        disp_pkt_rs0.uinstr.src1_optype = OP_REG;
        disp_pkt_rs0.uinstr.src2_optype = OP_REG;
        disp_pkt_rs0.robid              = robid;
        disp_pkt_rs0.pdst               = 7'h40 | 7'(robid);
        disp_pkt_rs0.psrc1              = psrc1;
        disp_pkt_rs0.src1_rdy           = rdy1;
        disp_pkt_rs0.src1_val           = val1;
        disp_pkt_rs0.psrc2              = psrc2;
        disp_pkt_rs0.src2_rdy           = rdy2;
        disp_pkt_rs0.src2_val           = val2;
    endtask

    task automatic set_wb(input logic [6:0] pdst, input logic [31:0] data);
        iprf_wr_en_ex1       = 1'b1;
        iprf_wr_pkt_ex1.pdst = pdst;
        iprf_wr_pkt_ex1.data = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clr();
        tick();
        tick();
        reset = 1'b0;
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL reset.iss: got %0b want 0", iss_ex0); end
        checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL reset.full: got %0b want 0", rs_full_rs0); end
        checks++; if (iss_pkt_ex0 !== t_iss_pkt'(0)) begin errors++; $display("FAIL reset.pkt: got %h want 0", iss_pkt_ex0); end
    endtask

    task automatic test_ready_issue();
        set_disp(6'd1, 7'd1, 1'b1, 32'd5, 7'd2, 1'b1, 32'd7);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL ready.early_iss: got %0b want 0", iss_ex0); end
        tick();
        checks++; if (iss_ex0 !== 1'b1) begin errors++; $display("FAIL ready.iss: got %0b want 1", iss_ex0); end
        checks++; if (iss_pkt_ex0.src1_val !== 32'd5) begin errors++; $display("FAIL ready.src1: got %0d want 5", iss_pkt_ex0.src1_val); end
        checks++; if (iss_pkt_ex0.src2_val !== 32'd7) begin errors++; $display("FAIL ready.src2: got %0d want 7", iss_pkt_ex0.src2_val); end
        checks++; if (iss_pkt_ex0.pdst !== 7'h41) begin errors++; $display("FAIL ready.pdst: got %h want 41", iss_pkt_ex0.pdst); end
        tick();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL ready.freed: got %0b want 0", iss_ex0); end
        checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL ready.full: got %0b want 0", rs_full_rs0); end
    endtask

    task automatic test_wakeup();
        set_disp(6'd2, 7'd12, 1'b0, 32'd0, 7'd13, 1'b1, 32'h11);
        tick(); clr();
        tick();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL wake.waiting: got %0b want 0", iss_ex0); end
        set_wb(7'd12, 32'hdead);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL wake.same_cycle: got %0b want 0", iss_ex0); end
        tick();
        checks++; if (iss_ex0 !== 1'b1) begin errors++; $display("FAIL wake.iss: got %0b want 1", iss_ex0); end
        checks++; if (iss_pkt_ex0.src1_val !== 32'hdead) begin errors++; $display("FAIL wake.src1: got %h want dead", iss_pkt_ex0.src1_val); end
        checks++; if (iss_pkt_ex0.src2_val !== 32'h11) begin errors++; $display("FAIL wake.src2: got %h want 11", iss_pkt_ex0.src2_val); end
        tick();
    endtask

    task automatic test_bypass();
        set_disp(6'd3, 7'd14, 1'b1, 32'h44, 7'd9, 1'b0, 32'h99);
        set_wb(7'd9, 32'h33);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL bypass.early: got %0b want 0", iss_ex0); end
        tick();
        checks++; if (iss_ex0 !== 1'b1) begin errors++; $display("FAIL bypass.iss: got %0b want 1", iss_ex0); end
        checks++; if (iss_pkt_ex0.src2_val !== 32'h33) begin errors++; $display("FAIL bypass.src2: got %h want 33", iss_pkt_ex0.src2_val); end
        checks++; if (iss_pkt_ex0.src1_val !== 32'h44) begin errors++; $display("FAIL bypass.src1: got %h want 44", iss_pkt_ex0.src1_val); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_disp(6'd50, 7'd1, 1'b1, 32'd1, 7'd2, 1'b1, 32'd2);
        tick();
        set_disp(6'd51, 7'd1, 1'b1, 32'd3, 7'd2, 1'b1, 32'd4);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd50) begin errors++; $display("FAIL b2b.first: got v=%0b rob=%0d want v=1 rob=50", iss_ex0, iss_pkt_ex0.robid); end
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd51) begin errors++; $display("FAIL b2b.second: got v=%0b rob=%0d want v=1 rob=51", iss_ex0, iss_pkt_ex0.robid); end
        tick();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL b2b.idle: got %0b want 0", iss_ex0); end
    endtask

    task automatic test_fill_order();
        for (int i = 0; i < 8; i++) begin
            checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL fill.not_full[%0d]: got %0b want 0", i, rs_full_rs0); end
            if (rs_full_rs0 === 1'b0) set_disp(6'(8 + i), 7'd4, 1'b0, 32'd0, 7'd5, 1'b1, 32'(i));
            tick(); clr();
        end
        checks++; if (rs_full_rs0 !== 1'b1) begin errors++; $display("FAIL fill.full: got %0b want 1", rs_full_rs0); end
        set_wb(7'd4, 32'h400);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL fill.wake_iss: got %0b want 0", iss_ex0); end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'(8 + i) || iss_pkt_ex0.src1_val !== 32'h400 || iss_pkt_ex0.src2_val !== 32'(i))
                begin errors++; $display("FAIL fill.order[%0d]: got v=%0b rob=%0d s1=%h s2=%h want rob=%0d s1=400 s2=%h", i, iss_ex0, iss_pkt_ex0.robid, iss_pkt_ex0.src1_val, iss_pkt_ex0.src2_val, 8 + i, i); end
        end
        tick();
        checks++; if (iss_ex0 !== 1'b0 || rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL fill.drained: got v=%0b full=%0b want 0/0", iss_ex0, rs_full_rs0); end
    endtask

    task automatic test_age_reuse();
        set_disp(6'd20, 7'd60, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick();
        set_disp(6'd21, 7'd51, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick();
        set_disp(6'd22, 7'd60, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick(); clr();
        set_wb(7'd51, 32'h51);
        tick(); clr();
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd21) begin errors++; $display("FAIL age.b: got v=%0b rob=%0d want v=1 rob=21", iss_ex0, iss_pkt_ex0.robid); end
        set_disp(6'd23, 7'd60, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick(); clr();
        set_wb(7'd60, 32'h60);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL age.wait: got %0b want 0", iss_ex0); end
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd20) begin errors++; $display("FAIL age.first: got v=%0b rob=%0d want v=1 rob=20", iss_ex0, iss_pkt_ex0.robid); end
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd22) begin errors++; $display("FAIL age.second: got v=%0b rob=%0d want v=1 rob=22", iss_ex0, iss_pkt_ex0.robid); end
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd23 || iss_pkt_ex0.src1_val !== 32'h60) begin errors++; $display("FAIL age.third: got v=%0b rob=%0d s1=%h want v=1 rob=23 s1=60", iss_ex0, iss_pkt_ex0.robid, iss_pkt_ex0.src1_val); end
        tick();
    endtask

    task automatic test_nuke();
        set_disp(6'd30, 7'd70, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick();
        set_disp(6'd31, 7'd70, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        tick();
        set_disp(6'd32, 7'd71, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
        set_wb(7'd70, 32'h70);
        tick(); clr();
        nuke_rb1.valid = 1'b1;
        set_disp(6'd33, 7'd1, 1'b1, 32'd0, 7'd1, 1'b1, 32'd0);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL nuke.suppress: got %0b want 0", iss_ex0); end
        checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL nuke.full: got %0b want 0", rs_full_rs0); end
        set_wb(7'd71, 32'h71);
        tick(); clr();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL nuke.cleared: got v=%0b rob=%0d want 0", iss_ex0, iss_pkt_ex0.robid); end
        tick();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL nuke.dropped: got v=%0b rob=%0d want 0", iss_ex0, iss_pkt_ex0.robid); end
        set_disp(6'd34, 7'd1, 1'b1, 32'd9, 7'd1, 1'b1, 32'd9);
        tick(); clr();
        tick();
        checks++; if (iss_ex0 !== 1'b1 || iss_pkt_ex0.robid !== 6'd34) begin errors++; $display("FAIL nuke.recover: got v=%0b rob=%0d want v=1 rob=34", iss_ex0, iss_pkt_ex0.robid); end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            set_disp(6'(40 + i), 7'd80, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
            tick();
        end
        clr();
        set_wb(7'd80, 32'h80);
        tick(); clr();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL rstmid.iss: got %0b want 0", iss_ex0); end
        checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL rstmid.full: got %0b want 0", rs_full_rs0); end
        tick();
        checks++; if (iss_ex0 !== 1'b0) begin errors++; $display("FAIL rstmid.stale: got v=%0b rob=%0d want 0", iss_ex0, iss_pkt_ex0.robid); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rs_full_rs0 !== 1'b0) begin errors++; $display("FAIL rstmid.alloc[%0d]: got full=%0b want 0", i, rs_full_rs0); end
            if (rs_full_rs0 === 1'b0) set_disp(6'(i), 7'd81, 1'b0, 32'd0, 7'd1, 1'b1, 32'd0);
            tick(); clr();
        end
        checks++; if (rs_full_rs0 !== 1'b1) begin errors++; $display("FAIL rstmid.full8: got %0b want 1", rs_full_rs0); end
    endtask

    initial begin
        reset = 1'b1;
        clr();
        test_reset();
        test_ready_issue();
        test_wakeup();
        test_bypass();
        test_back_to_back();
        test_fill_order();
        test_age_reuse();
        test_nuke();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
